inst_fetch_ctrl: RTL and testbench
==================================

// Module: inst_fetch_ctrl
// PURPOSE
// Consumer side of the PC interface: reads the instruction at pc_i from instruction memory
// over a req/gnt/rvalid handshake, holds it for decode with a valid/ready handshake, and
// returns pc_sel_o/imm26_o plus an advance strobe pc_en_o that the PC register uses as its enable.
// Sits between the PC register, instruction memory and the decode/control stage.
// PARAMETERS
// TIMEOUT   255            max cycles in WAIT before err_o sets (8-bit counter)
// RESET_PC  32'h0000_3000  expected first fetch address; used only by the bench as a cross-check
// PORTS
// clk           in   1   clock, rising edge
// rst_n         in   1   reset, asynchronous, active-high
// pc_i          in   32  current PC; changes only on the edge where pc_en_o=1
// mem_req_o     out  1   instruction memory read request
// mem_addr_o    out  32  read address (= pc_i)
// mem_gnt_i     in   1   memory accepted request this cycle
// mem_rvalid_i  in   1   read data valid
// mem_rdata_i   in   32  read data
// inst_valid_o  out  1   inst_o holds a fetched instruction
// inst_o        out  32  fetched instruction
// inst_ready_i  in   1   decode accepts inst_o
// br_cond_i     in   1   datapath compare result (rs==rt) for the held instruction
// pc_en_o       out  1   one-cycle PC advance strobe
// pc_sel_o      out  2   00 seq (+4), 01 branch, 10 jump; matches PC encoding
// imm26_o       out  26  inst_o[25:0]
// err_o         out  1   sticky: misaligned pc_i or memory timeout
// BEHAVIOUR
// - Reset: state IDLE; mem_req_o, inst_valid_o, pc_en_o, err_o = 0; inst_o = 0; pc_sel_o = 00; timeout counter = 0.
// - FSM IDLE -> REQ after one cycle (first fetch from the post-reset PC).
// - REQ: mem_req_o=1, mem_addr_o=pc_i. If pc_i[1:0]!=0: set err_o, go ERR, no request.
//   If gnt & rvalid same cycle: capture rdata, go HOLD. If gnt only: go WAIT. Otherwise stay.
//   rvalid without gnt in REQ is ignored.
// - WAIT: mem_req_o=0; counter++ each cycle. On rvalid: capture rdata into inst_o, clear counter, go HOLD.
//   When counter==TIMEOUT without rvalid: set err_o, go ERR.
// - HOLD: inst_valid_o=1; inst_o is stable. On inst_valid_o&inst_ready_i: pc_en_o=1 for that cycle
//   (combinational), go REQ. The PC updates on that edge, so the next REQ uses the new pc_i.
// - ERR: all strobes 0, terminal; only rst_n exits.
// - pc_sel_o/imm26_o decode from inst_o[31:26] (combinational, meaningful only when pc_en_o=1):
//   000010 j / 000011 jal -> 10; 000100 beq & br_cond_i -> 01; 000101 bne & !br_cond_i -> 01; else 00.
//   imm26_o = inst_o[25:0] always.
// - Latency: zero-wait memory gives 1 REQ + 1 HOLD = 2 cycles per instruction. Each wait cycle adds 1.
// - Reset mid-operation: aborts immediately; the outstanding response is never captured
//   (no WAIT state follows reset without a fresh gnt).
// - At most one outstanding request; mem_req_o never asserts in WAIT, HOLD or ERR.
// STRUCTURE
// - Shared package: state encoding (IDLE, REQ, WAIT, HOLD, ERR), pc_sel encodings (PCSEL_SEQ/BR/J),
//   opcode constants (OP_J, OP_JAL, OP_BEQ, OP_BNE); the PC register reuses the pc_sel constants.
// - One sub-module: fetch_next_decode, combinational (inst[31:26], br_cond_i) -> pc_sel.
// TESTING
// 1) Reset release, pc_i=0x3000, zero-wait memory returning 0x00000000 (nop):
//    mem_req at cycle 1, inst_valid at cycle 2, pc_en=1 and pc_sel=00 on ready.
// 2) Memory: gnt at cycle 1, rvalid 3 cycles later with 0x08000C10 (j):
//    inst_o=0x08000C10, pc_sel=10, imm26=0x0000C10 on pc_en.
// 3) beq 0x1000FFFF with br_cond_i=1 -> pc_sel=01, imm26[15:0]=FFFF.
//    Same instruction with br_cond_i=0 -> pc_sel=00.
// 4) inst_ready_i held low 10 cycles: inst_valid and inst_o stay stable, no new mem_req, pc_en=0 throughout.
// 5) pc_i=0x3002 -> err_o=1, no mem_req. Separately: gnt with no rvalid for TIMEOUT cycles -> err_o=1, FSM inert.
// 6) rst_n pulse while in WAIT, then a late rvalid arrives in REQ without gnt: it is ignored, and the
//    next fetch completes normally.

Source files
------------

// File: rtl/inst_fetch_ctrl_pkg.sv
// Shared fetch-control definitions: FSM states, PC-select encodings and the
// control-flow opcodes that the PC register and fetch decode agree on.
package inst_fetch_ctrl_pkg;

  localparam int unsigned XLEN          = 32;
  localparam int unsigned IMM26_W       = 26;
  localparam int unsigned OPC_W         = 6;
  localparam int unsigned CNT_W         = 8;
  localparam int unsigned FETCH_TIMEOUT = 255;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    REQ  = 3'd1,
    WAIT = 3'd2,
    HOLD = 3'd3,
    ERR  = 3'd4
  } fetch_state_e;

  localparam logic [1:0] PCSEL_SEQ = 2'b00;
  localparam logic [1:0] PCSEL_BR  = 2'b01;
  localparam logic [1:0] PCSEL_J   = 2'b10;

  localparam logic [OPC_W-1:0] OP_J   = 6'b000010;
  localparam logic [OPC_W-1:0] OP_JAL = 6'b000011;
  localparam logic [OPC_W-1:0] OP_BEQ = 6'b000100;
  localparam logic [OPC_W-1:0] OP_BNE = 6'b000101;

endpackage

// File: rtl/inst_fetch_ctrl_next_decode.sv
// Combinational next-PC source selection from the held opcode and the
// datapath branch compare.
module fetch_next_decode
  import inst_fetch_ctrl_pkg::*;
(
  input  logic [OPC_W-1:0] opcode_i,
  input  logic             br_cond_i,
  output logic [1:0]       pc_sel_o
);

  always_comb begin
    pc_sel_o = PCSEL_SEQ;
    if (opcode_i == OP_J || opcode_i == OP_JAL) begin
      pc_sel_o = PCSEL_J;
    end else if ((opcode_i == OP_BEQ && br_cond_i) || (opcode_i == OP_BNE && !br_cond_i)) begin
      pc_sel_o = PCSEL_BR;
    end
  end

endmodule

// File: rtl/inst_fetch_ctrl.sv
// Instruction fetch controller: one outstanding memory read per PC, holds the
// fetched word for decode and strobes the PC enable when decode accepts it.
module inst_fetch_ctrl
  import inst_fetch_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT = FETCH_TIMEOUT
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [XLEN-1:0]    pc_i,
  output logic               mem_req_o,
  output logic [XLEN-1:0]    mem_addr_o,
  input  logic               mem_gnt_i,
  input  logic               mem_rvalid_i,
  input  logic [XLEN-1:0]    mem_rdata_i,
  output logic               inst_valid_o,
  output logic [XLEN-1:0]    inst_o,
  input  logic               inst_ready_i,
  input  logic               br_cond_i,
  output logic               pc_en_o,
  output logic [1:0]         pc_sel_o,
  output logic [IMM26_W-1:0] imm26_o,
  output logic               err_o
);

  fetch_state_e     state_q, state_d;
  logic [XLEN-1:0]  inst_q, inst_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;
  logic             mem_req_c;
  logic             pc_en_c;

  // Reset is active-high here to match the surrounding codebase.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state_q <= IDLE;
      inst_q  <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      inst_q  <= inst_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    inst_d    = inst_q;
    cnt_d     = cnt_q;
    err_d     = err_q;
    mem_req_c = 1'b0;
    pc_en_c   = 1'b0;
    case (state_q)
      IDLE: state_d = REQ;
      REQ: begin
        // A misaligned PC is never sent to memory.
        if (pc_i[1:0] != 2'b00) begin
          err_d   = 1'b1;
          state_d = ERR;
        end else begin
          mem_req_c = 1'b1;
          if (mem_gnt_i && mem_rvalid_i) begin
            inst_d  = mem_rdata_i;
            state_d = HOLD;
          end else if (mem_gnt_i) begin
            cnt_d   = '0;
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        if (mem_rvalid_i) begin
          inst_d  = mem_rdata_i;
          cnt_d   = '0;
          state_d = HOLD;
        end else if (cnt_q == CNT_W'(TIMEOUT)) begin
          err_d   = 1'b1;
          state_d = ERR;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      HOLD: begin
        if (inst_ready_i) begin
          pc_en_c = 1'b1;
          state_d = REQ;
        end
      end
      ERR:     state_d = ERR;
      default: state_d = ERR;
    endcase
  end

  fetch_next_decode u_next_decode (
    .opcode_i  (inst_q[XLEN-1:XLEN-OPC_W]),
    .br_cond_i (br_cond_i),
    .pc_sel_o  (pc_sel_o)
  );

  assign mem_req_o    = mem_req_c;
  assign mem_addr_o   = pc_i;
  assign pc_en_o      = pc_en_c;
  assign inst_valid_o = (state_q == HOLD);
  assign inst_o       = inst_q;
  assign imm26_o      = inst_q[IMM26_W-1:0];
  assign err_o        = err_q;

endmodule

// File: tb/tb_inst_fetch_ctrl.sv
// Bench for inst_fetch_ctrl: directed scenarios plus a randomized run against a
// program-level model that owns the PC register and a lazily filled memory.
module tb_inst_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [31:0] pc_i = 32'h0000_3000;
  logic        mem_req_o;
  logic [31:0] mem_addr_o;
  logic        mem_gnt_i, mem_rvalid_i;
  logic [31:0] mem_rdata_i;
  logic        inst_valid_o;
  logic [31:0] inst_o;
  logic        inst_ready_i, br_cond_i;
  logic        pc_en_o;
  logic [1:0]  pc_sel_o;
  logic [25:0] imm26_o;
  logic        err_o;

  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0] imem [logic [31:0]];

  inst_fetch_ctrl dut (
    .clk(clk), .rst_n(rst_n), .pc_i(pc_i),
    .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o), .mem_gnt_i(mem_gnt_i),
    .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i),
    .inst_valid_o(inst_valid_o), .inst_o(inst_o), .inst_ready_i(inst_ready_i),
    .br_cond_i(br_cond_i), .pc_en_o(pc_en_o), .pc_sel_o(pc_sel_o),
    .imm26_o(imm26_o), .err_o(err_o)
  );

  always #5 clk = ~clk;

  task automatic clr_inputs();
    mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0; mem_rdata_i = '0;
    inst_ready_i = 1'b0; br_cond_i = 1'b0;
  endtask

  // Leaves the bench at the negedge of cycle 0 (first cycle out of reset).
  task automatic do_reset(input logic [31:0] pc);
    clr_inputs();
    pc_i = pc;
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
  endtask

  // Called at a REQ negedge; returns at the first HOLD negedge.
  task automatic fetch_resp(input logic [31:0] data, input int waits);
    mem_gnt_i = 1'b1;
    if (waits == 0) begin mem_rvalid_i = 1'b1; mem_rdata_i = data; end
    @(negedge clk);
    clr_inputs();
    if (waits > 0) begin
      repeat (waits - 1) @(negedge clk);
      mem_rvalid_i = 1'b1; mem_rdata_i = data;
      @(negedge clk);
      clr_inputs();
    end
  endtask

  task automatic get_word(input logic [31:0] a, output logic [31:0] w);
    if (!imem.exists(a)) begin
      case ($urandom_range(0, 4))
        0:       imem[a] = {6'b000010, 26'($urandom)};
        1:       imem[a] = {6'b000011, 26'($urandom)};
        2:       imem[a] = {6'b000100, 26'($urandom)};
        3:       imem[a] = {6'b000101, 26'($urandom)};
        default: imem[a] = $urandom;
      endcase
    end
    w = imem[a];
  endtask

  task automatic test_reset();
    clr_inputs();
    pc_i = 32'h0000_3000;
    rst_n = 1'b1;
    inst_ready_i = 1'b1;
    @(negedge clk);
    #1;
    n_tests++; if (mem_req_o !== 1'b0) begin n_fail++; $display("FAIL reset_mem_req: got %b want 0", mem_req_o); end
    n_tests++; if (inst_valid_o !== 1'b0) begin n_fail++; $display("FAIL reset_inst_valid: got %b want 0", inst_valid_o); end
    n_tests++; if (pc_en_o !== 1'b0) begin n_fail++; $display("FAIL reset_pc_en: got %b want 0", pc_en_o); end
    n_tests++; if (err_o !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b want 0", err_o); end
    n_tests++; if (inst_o !== 32'h0) begin n_fail++; $display("FAIL reset_inst: got %h want 0", inst_o); end
    n_tests++; if (pc_sel_o !== 2'b00) begin n_fail++; $display("FAIL reset_pc_sel: got %b want 00", pc_sel_o); end
    clr_inputs();
  endtask

  task automatic test_nop();
    do_reset(32'h0000_3000);
    n_tests++; if (mem_req_o !== 1'b0) begin n_fail++; $display("FAIL nop_idle_req: got %b want 0", mem_req_o); end
    @(negedge clk);
    n_tests++; if (mem_req_o !== 1'b1) begin n_fail++; $display("FAIL nop_req_c1: got %b want 1", mem_req_o); end
    n_tests++; if (mem_addr_o !== 32'h0000_3000) begin n_fail++; $display("FAIL nop_addr: got %h want 00003000", mem_addr_o); end
    n_tests++; if (inst_valid_o !== 1'b0) begin n_fail++; $display("FAIL nop_valid_c1: got %b want 0", inst_valid_o); end
    fetch_resp(32'h0000_0000, 0);
    n_tests++; if (inst_valid_o !== 1'b1) begin n_fail++; $display("FAIL nop_valid_c2: got %b want 1", inst_valid_o); end
    n_tests++; if (mem_req_o !== 1'b0) begin n_fail++; $display("FAIL nop_req_hold: got %b want 0", mem_req_o); end
    inst_ready_i = 1'b1;
    #1;
    n_tests++; if (pc_en_o !== 1'b1) begin n_fail++; $display("FAIL nop_pc_en: got %b want 1", pc_en_o); end
    n_tests++; if (pc_sel_o !== 2'b00) begin n_fail++; $display("FAIL nop_pc_sel: got %b want 00", pc_sel_o); end
    @(negedge clk);
    clr_inputs();
    n_tests++; if (mem_req_o !== 1'b1 || inst_valid_o !== 1'b0) begin n_fail++; $display("FAIL nop_back_to_req: got req=%b valid=%b want req=1 valid=0", mem_req_o, inst_valid_o); end
  endtask

  task automatic test_jump();
    do_reset(32'h0000_3000);
    @(negedge clk);
    fetch_resp(32'h0800_0C10, 3);
    n_tests++; if (inst_valid_o !== 1'b1 || inst_o !== 32'h0800_0C10) begin n_fail++; $display("FAIL jump_inst: got valid=%b inst=%h want 1 08000c10", inst_valid_o, inst_o); end
    inst_ready_i = 1'b1;
    #1;
    n_tests++; if (pc_en_o !== 1'b1) begin n_fail++; $display("FAIL jump_pc_en: got %b want 1", pc_en_o); end
    n_tests++; if (pc_sel_o !== 2'b10) begin n_fail++; $display("FAIL jump_pc_sel: got %b want 10", pc_sel_o); end
    n_tests++; if (imm26_o !== 26'h0000C10) begin n_fail++; $display("FAIL jump_imm26: got %h want 0000c10", imm26_o); end
    @(negedge clk);
    clr_inputs();
  endtask

  task automatic test_branch();
    logic [31:0] insts [4] = '{32'h1000_FFFF, 32'h1000_FFFF, 32'h1400_0010, 32'h0C00_0040};
    logic        conds [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    logic [1:0]  sels  [4] = '{2'b01, 2'b00, 2'b01, 2'b10};
    do_reset(32'h0000_3000);
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      fetch_resp(insts[i], i);
      br_cond_i = conds[i];
      inst_ready_i = 1'b1;
      #1;
      n_tests++; if (pc_en_o !== 1'b1 || pc_sel_o !== sels[i]) begin n_fail++; $display("FAIL branch_sel[%0d]: got en=%b sel=%b want en=1 sel=%b", i, pc_en_o, pc_sel_o, sels[i]); end
      n_tests++; if (imm26_o[15:0] !== insts[i][15:0]) begin n_fail++; $display("FAIL branch_imm[%0d]: got %h want %h", i, imm26_o[15:0], insts[i][15:0]); end
      @(negedge clk);
      clr_inputs();
    end
  endtask

  task automatic test_stall();
    do_reset(32'h0000_3000);
    @(negedge clk);
    fetch_resp(32'h2345_6789, 1);
    for (int i = 0; i < 10; i++) begin
      mem_gnt_i = 1'b1;
      #1;
      n_tests++; if (inst_valid_o !== 1'b1 || inst_o !== 32'h2345_6789) begin n_fail++; $display("FAIL stall_hold[%0d]: got valid=%b inst=%h want 1 23456789", i, inst_valid_o, inst_o); end
      n_tests++; if (mem_req_o !== 1'b0 || pc_en_o !== 1'b0) begin n_fail++; $display("FAIL stall_strobes[%0d]: got req=%b en=%b want 0 0", i, mem_req_o, pc_en_o); end
      @(negedge clk);
    end
    clr_inputs();
    inst_ready_i = 1'b1;
    #1;
    n_tests++; if (pc_en_o !== 1'b1) begin n_fail++; $display("FAIL stall_release: got %b want 1", pc_en_o); end
    @(negedge clk);
    clr_inputs();
  endtask

  task automatic check_inert(input string name);
    for (int i = 0; i < 4; i++) begin
      mem_gnt_i = 1'b1; mem_rvalid_i = 1'b1; mem_rdata_i = 32'hCAFE_F00D; inst_ready_i = 1'b1;
      #1;
      n_tests++; if (err_o !== 1'b1 || mem_req_o !== 1'b0 || inst_valid_o !== 1'b0 || pc_en_o !== 1'b0) begin
        n_fail++; $display("FAIL %s_inert[%0d]: got err=%b req=%b valid=%b en=%b want 1 0 0 0", name, i, err_o, mem_req_o, inst_valid_o, pc_en_o);
      end
      @(negedge clk);
    end
    clr_inputs();
  endtask

  task automatic test_misalign();
    do_reset(32'h0000_3002);
    @(negedge clk);
    n_tests++; if (mem_req_o !== 1'b0) begin n_fail++; $display("FAIL misalign_req: got %b want 0", mem_req_o); end
    n_tests++; if (err_o !== 1'b0) begin n_fail++; $display("FAIL misalign_err_early: got %b want 0", err_o); end
    @(negedge clk);
    check_inert("misalign");
  endtask

  task automatic test_timeout(input logic late_rvalid);
    do_reset(32'h0000_3000);
    @(negedge clk);
    mem_gnt_i = 1'b1;
    @(negedge clk);
    clr_inputs();
    repeat (255) @(negedge clk);
    n_tests++; if (err_o !== 1'b0 || inst_valid_o !== 1'b0) begin n_fail++; $display("FAIL timeout_pre: got err=%b valid=%b want 0 0", err_o, inst_valid_o); end
    if (late_rvalid) begin
      mem_rvalid_i = 1'b1; mem_rdata_i = 32'h1357_9BDF;
      @(negedge clk);
      clr_inputs();
      n_tests++; if (err_o !== 1'b0 || inst_valid_o !== 1'b1 || inst_o !== 32'h1357_9BDF) begin
        n_fail++; $display("FAIL timeout_edge_capture: got err=%b valid=%b inst=%h want 0 1 13579bdf", err_o, inst_valid_o, inst_o);
      end
    end else begin
      @(negedge clk);
      n_tests++; if (err_o !== 1'b1) begin n_fail++; $display("FAIL timeout_err: got %b want 1", err_o); end
      check_inert("timeout");
    end
  endtask

  task automatic test_reset_wait();
    do_reset(32'h0000_3000);
    @(negedge clk);
    mem_gnt_i = 1'b1;
    @(negedge clk);
    clr_inputs();
    rst_n = 1'b1;
    #1;
    n_tests++; if (mem_req_o !== 1'b0 || inst_valid_o !== 1'b0) begin n_fail++; $display("FAIL rstwait_async: got req=%b valid=%b want 0 0", mem_req_o, inst_valid_o); end
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    mem_rvalid_i = 1'b1; mem_rdata_i = 32'hDEAD_BEEF;
    @(negedge clk);
    clr_inputs();
    n_tests++; if (inst_valid_o !== 1'b0 || mem_req_o !== 1'b1 || err_o !== 1'b0) begin
      n_fail++; $display("FAIL rstwait_stray_rvalid: got valid=%b req=%b err=%b want 0 1 0", inst_valid_o, mem_req_o, err_o);
    end
    fetch_resp(32'h0C00_0040, 2);
    inst_ready_i = 1'b1;
    #1;
    n_tests++; if (inst_o !== 32'h0C00_0040 || pc_en_o !== 1'b1 || pc_sel_o !== 2'b10) begin
      n_fail++; $display("FAIL rstwait_refetch: got inst=%h en=%b sel=%b want 0c000040 1 10", inst_o, pc_en_o, pc_sel_o);
    end
    @(negedge clk);
    clr_inputs();
  endtask

  // Phases: 0 first cycle after reset, 1 fetch needed, 2 response outstanding, 3 word held.
  task automatic test_random(input int ncyc);
    logic [31:0] pc, word, nxt, pc4, exp_inst;
    logic [5:0]  op;
    logic [1:0]  exp_sel;
    logic        take;
    int          phase, ph, delay, waited, retired;
    pc = 32'h0000_3000;
    do_reset(pc);
    phase = 0; retired = 0; delay = 0; waited = 0; exp_inst = '0; nxt = pc;
    for (int c = 0; c < ncyc; c++) begin
      ph = phase;
      n_tests++; if (mem_req_o !== (ph == 1)) begin n_fail++; $display("FAIL rand_req c%0d: got %b want %b", c, mem_req_o, ph == 1); end
      n_tests++; if (inst_valid_o !== (ph == 3)) begin n_fail++; $display("FAIL rand_valid c%0d: got %b want %b", c, inst_valid_o, ph == 3); end
      n_tests++; if (err_o !== 1'b0) begin n_fail++; $display("FAIL rand_err c%0d: got %b want 0", c, err_o); end
      if (ph == 1) begin
        n_tests++; if (mem_addr_o !== pc) begin n_fail++; $display("FAIL rand_addr c%0d: got %h want %h", c, mem_addr_o, pc); end
      end
      if (ph == 3) begin
        n_tests++; if (inst_o !== exp_inst) begin n_fail++; $display("FAIL rand_inst c%0d: got %h want %h", c, inst_o, exp_inst); end
      end
      clr_inputs();
      br_cond_i = 1'($urandom_range(0, 1));
      take = 1'b0;
      case (ph)
        0: phase = 1;
        1: begin
          get_word(pc, word);
          if ($urandom_range(0, 3) != 0) begin
            mem_gnt_i = 1'b1;
            delay = $urandom_range(0, 3);
            if (delay == 0) begin
              mem_rvalid_i = 1'b1; mem_rdata_i = word; exp_inst = word; phase = 3;
            end else begin
              waited = 0; phase = 2;
            end
          end else if ($urandom_range(0, 1) == 1) begin
            mem_rvalid_i = 1'b1; mem_rdata_i = $urandom;
          end
        end
        2: begin
          waited++;
          if (waited == delay) begin
            get_word(pc, word);
            mem_rvalid_i = 1'b1; mem_rdata_i = word; exp_inst = word; phase = 3;
          end
        end
        default: begin
          inst_ready_i = 1'($urandom_range(0, 1));
          take = inst_ready_i;
        end
      endcase
      #1;
      n_tests++; if (pc_en_o !== take) begin n_fail++; $display("FAIL rand_pc_en c%0d: got %b want %b", c, pc_en_o, take); end
      if (take) begin
        op  = exp_inst[31:26];
        pc4 = pc + 32'd4;
        if (op == 6'd2 || op == 6'd3) begin
          exp_sel = 2'b10; nxt = {pc4[31:28], exp_inst[25:0], 2'b00};
        end else if ((op == 6'd4 && br_cond_i) || (op == 6'd5 && !br_cond_i)) begin
          exp_sel = 2'b01; nxt = pc4 + {{14{exp_inst[15]}}, exp_inst[15:0], 2'b00};
        end else begin
          exp_sel = 2'b00; nxt = pc4;
        end
        n_tests++; if (pc_sel_o !== exp_sel) begin n_fail++; $display("FAIL rand_pc_sel c%0d: got %b want %b inst=%h", c, pc_sel_o, exp_sel, exp_inst); end
        n_tests++; if (imm26_o !== exp_inst[25:0]) begin n_fail++; $display("FAIL rand_imm26 c%0d: got %h want %h", c, imm26_o, exp_inst[25:0]); end
      end
      @(negedge clk);
      if (take) begin
        pc = nxt; pc_i = pc; phase = 1; retired++;
      end
    end
    clr_inputs();
    n_tests++; if (retired < ncyc / 10) begin n_fail++; $display("FAIL rand_progress: got %0d retired want >= %0d", retired, ncyc / 10); end
  endtask

  initial begin
    clr_inputs();
    test_reset();
    test_nop();
    test_jump();
    test_branch();
    test_stall();
    test_misalign();
    test_timeout(1'b0);
    test_timeout(1'b1);
    test_reset_wait();
    test_random(2000);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
